// File: rtl/handshake_pkg.sv
// Shared constants and helpers for the registered handshake node family.
package handshake_pkg;

    localparam int MODE_TABLE = 0;
    localparam int MODE_ARITH = 1;

    // Index width for n entries; a single-entry sequence still needs a 1-bit index.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/handshake_out_reg.sv
// Single-slot output register that accepts a new token in the same cycle the
// held one drains, so a full slot still sustains one token per cycle.
module handshake_out_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/handshake_constant_seq.sv
// Emits the next element of a compile-time sequence (table or arithmetic
// progression) for each accepted control token, through a registered slot.
module handshake_constant_seq
    import handshake_pkg::*;
#(
    parameter int                               DATA_WIDTH = 32,
    parameter int                               NUM_VALUES = 4,
    parameter int                               MODE       = MODE_TABLE,
    parameter logic [NUM_VALUES*DATA_WIDTH-1:0] VALUES     = '0,
    parameter logic [DATA_WIDTH-1:0]            BASE       = '0,
    parameter logic [DATA_WIDTH-1:0]            STEP       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam int IDX_W       = clog2_min1(NUM_VALUES);
    localparam int TABLE_DEPTH = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VALUES - 1);

    generate
        if (NUM_VALUES < 1 || MODE > 1) begin : g_illegal_params
            $error("handshake_constant_seq: NUM_VALUES must be >= 1 and MODE must be 0 or 1");
        end
    endgenerate

    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] cur_value;
    logic [DATA_WIDTH-1:0] table_mem [TABLE_DEPTH];
    logic                  ctrl_fire;

    // Padding entries keep the index range a power of two; they are never selected.
    generate
        for (genvar k = 0; k < TABLE_DEPTH; k++) begin : g_table
            if (k < NUM_VALUES) begin : g_used
                assign table_mem[k] = VALUES[k*DATA_WIDTH +: DATA_WIDTH];
            end else begin : g_pad
                assign table_mem[k] = '0;
            end
        end
    endgenerate

    assign cur_value = (MODE == MODE_ARITH) ? acc : table_mem[idx];
    assign ctrl_fire = ctrl_valid && ctrl_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= '0;
            acc <= BASE;
        end else if (ctrl_fire) begin
            if (idx == LAST_IDX) begin
                idx <= '0;
                acc <= BASE;
            end else begin
                idx <= idx + IDX_W'(1);
                acc <= acc + STEP;
            end
        end
    end

    handshake_out_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .in_valid (ctrl_valid),
        .in_ready (ctrl_ready),
        .in_data  (cur_value),
        .out_valid(outs_valid),
        .out_ready(outs_ready),
        .out_data (outs)
    );

endmodule

// File: tb/tb_handshake_constant_seq.sv
// Scoreboard bench: four configurations share one stimulus stream; expected
// sequence elements are queued on each control handshake and popped by a monitor.
module tb_handshake_constant_seq;
    import handshake_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ctrl_valid = 1'b0;
    logic outs_ready = 1'b0;

    always #5 clk = ~clk;

    logic [3:0]  c_ready;
    logic [3:0]  o_valid;
    logic [31:0] o_data [4];
    logic [31:0] outs_t;
    logic [31:0] outs_d;
    logic [7:0]  outs_a;
    logic [7:0]  outs_n;

    handshake_constant_seq #(
        .DATA_WIDTH(32), .NUM_VALUES(4), .MODE(MODE_TABLE),
        .VALUES(128'h00000004_00000003_00000002_00000001)
    ) u_table (
        .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(c_ready[0]),
        .outs(outs_t), .outs_valid(o_valid[0]), .outs_ready(outs_ready)
    );

    handshake_constant_seq #(
        .DATA_WIDTH(8), .NUM_VALUES(4), .MODE(MODE_ARITH),
        .BASE(8'hFE), .STEP(8'h01)
    ) u_arith (
        .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(c_ready[1]),
        .outs(outs_a), .outs_valid(o_valid[1]), .outs_ready(outs_ready)
    );

    handshake_constant_seq #(
        .DATA_WIDTH(8), .NUM_VALUES(3), .MODE(MODE_ARITH),
        .BASE(8'd10), .STEP(8'hFD)
    ) u_neg (
        .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(c_ready[2]),
        .outs(outs_n), .outs_valid(o_valid[2]), .outs_ready(outs_ready)
    );

    handshake_constant_seq #(
        .DATA_WIDTH(32), .NUM_VALUES(1), .MODE(MODE_TABLE),
        .VALUES(32'h000000A5)
    ) u_degen (
        .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(c_ready[3]),
        .outs(outs_d), .outs_valid(o_valid[3]), .outs_ready(outs_ready)
    );

    assign o_data[0] = outs_t;
    assign o_data[1] = {24'h0, outs_a};
    assign o_data[2] = {24'h0, outs_n};
    assign o_data[3] = outs_d;

    logic [31:0] seq_tab [4][4];
    int          seq_len [4];
    int          seq_k   [4];
    logic [31:0] exp_q   [4][$];
    int          n_in    [4];
    int          n_out   [4];
    int          checks = 0;
    int          passes = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // One cycle per call: drive just after the rising edge, log handshakes at the falling edge.
    task automatic applyStimulus(input logic cv, input logic ordy, input int ncycles);
        for (int c = 0; c < ncycles; c++) begin
            @(posedge clk);
            #1;
            ctrl_valid = cv;
            outs_ready = ordy;
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (ctrl_valid && c_ready[i]) begin
                    exp_q[i].push_back(seq_tab[i][seq_k[i]]);
                    seq_k[i] = (seq_k[i] + 1) % seq_len[i];
                    n_in[i]++;
                end
            end
        end
    endtask

    task automatic doReset();
        rst = 1'b0;
        #1;
        checkOutput("reset_valid", {28'h0, o_valid}, 32'h0);
        checkOutput("reset_outs_table", o_data[0], 32'h0);
        checkOutput("reset_outs_arith", o_data[1], 32'h0);
        checkOutput("reset_ctrl_ready", {28'h0, c_ready}, 32'hF);
        for (int i = 0; i < 4; i++) begin
            exp_q[i].delete();
            seq_k[i] = 0;
            n_in[i]  = 0;
            n_out[i] = 0;
        end
        ctrl_valid = 1'b0;
        outs_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("no_valid_after_release", {28'h0, o_valid}, 32'h0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                if (o_valid[i]) begin
                    if (exp_q[i].size() == 0) begin
                        checkOutput($sformatf("inst%0d_expected_tokens", i), 32'(exp_q[i].size()), 32'd1);
                    end else if (outs_ready) begin
                        checkOutput($sformatf("inst%0d_outs", i), o_data[i], exp_q[i].pop_front());
                        n_out[i]++;
                    end else begin
                        checkOutput($sformatf("inst%0d_hold", i), o_data[i], exp_q[i][0]);
                    end
                end
            end
        end
    end

    initial begin
        seq_tab = '{'{32'd1, 32'd2, 32'd3, 32'd4},
                    '{32'hFE, 32'hFF, 32'h00, 32'h01},
                    '{32'd10, 32'd7, 32'd4, 32'd0},
                    '{32'hA5, 32'd0, 32'd0, 32'd0}};
        seq_len = '{4, 4, 3, 1};

        $display("[TB] reset and streaming");
        doReset();
        applyStimulus(1'b1, 1'b1, 1);
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b1, 1'b1, 1);
            checkOutput("stream_valid", {31'h0, o_valid[0]}, 32'h1);
        end
        applyStimulus(1'b0, 1'b1, 3);

        $display("[TB] back-pressure");
        doReset();
        applyStimulus(1'b1, 1'b0, 1);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b1, 1'b0, 1);
            checkOutput("stall_ctrl_ready", {28'h0, c_ready}, 32'h0);
        end
        applyStimulus(1'b1, 1'b1, 2);
        applyStimulus(1'b0, 1'b1, 3);

        $display("[TB] mid-sequence reset");
        doReset();
        applyStimulus(1'b1, 1'b1, 2);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("pre_reset_valid", {31'h0, o_valid[0]}, 32'h1);
        #2;
        doReset();
        applyStimulus(1'b1, 1'b1, 3);
        applyStimulus(1'b0, 1'b1, 3);

        $display("[TB] random bubbles");
        doReset();
        for (int c = 0; c < 1000; c++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
        end
        applyStimulus(1'b0, 1'b1, 3);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("inst%0d_drained", i), 32'(exp_q[i].size()), 32'd0);
            checkOutput($sformatf("inst%0d_count", i), 32'(n_out[i]), 32'(n_in[i]));
        end

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
